// File: rtl/bf16_divider.sv
// Multi-cycle bfloat16 divider: restoring mantissa division, RNE rounding,
// flush-to-zero on denormals, IEEE-style special-case handling.
module bf16_divider #(
  parameter int DATA_TYPE = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_TYPE-1:0] A,
  input  logic [DATA_TYPE-1:0] B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_TYPE-1:0] O
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [9:0]         r_q, r_d;
  logic [9:0]         q_q, q_d;
  logic               ph_q, ph_d;
  logic [6:0]         m_q, m_d;
  logic               g_q, g_d;
  logic               st_q, st_d;
  logic signed [9:0]  e_q, e_d;
  logic [15:0]        o_q, o_d;

  logic [9:0]         rsh;
  logic [9:0]         dvx;
  logic               ge;
  logic               sgn;
  logic               za, zb, ia, ib, na, nb;
  logic               inc;
  logic [7:0]         mr;
  logic signed [9:0]  ef;
  logic [15:0]        pk;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign O         = o_q;

  assign sgn = a_q[15] ^ b_q[15];
  assign za  = (a_q[14:7] == 8'h00);
  assign zb  = (b_q[14:7] == 8'h00);
  assign ia  = (a_q[14:7] == 8'hFF) && (a_q[6:0] == 7'h0);
  assign ib  = (b_q[14:7] == 8'hFF) && (b_q[6:0] == 7'h0);
  assign na  = (a_q[14:7] == 8'hFF) && (a_q[6:0] != 7'h0);
  assign nb  = (b_q[14:7] == 8'hFF) && (b_q[6:0] != 7'h0);

  // First step compares the raw dividend mantissa; later steps shift first.
  assign rsh = (cnt_q == 4'd0) ? r_q : {r_q[8:0], 1'b0};
  assign dvx = {2'b00, 1'b1, b_q[6:0]};
  assign ge  = (rsh >= dvx);

  assign inc = g_q & (st_q | m_q[0]);
  assign mr  = {1'b0, m_q} + {7'd0, inc};
  assign ef  = mr[7] ? (e_q + 10'sd1) : e_q;

  always_comb begin
    pk = 16'h0000;
    if (na || nb || (za && zb) || (ia && ib)) begin
      pk = 16'h7FC0;
    end else if (ia || zb) begin
      pk = {sgn, 8'hFF, 7'h00};
    end else if (za || ib) begin
      pk = {sgn, 15'h0000};
    end else if (ef >= 10'sd255) begin
      pk = {sgn, 8'hFF, 7'h00};
    end else if (ef <= 10'sd0) begin
      pk = {sgn, 15'h0000};
    end else begin
      pk = {sgn, ef[7:0], mr[7] ? 7'h00 : mr[6:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    ph_d    = ph_q;
    m_d     = m_q;
    g_d     = g_q;
    st_d    = st_q;
    e_d     = e_q;
    o_d     = o_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A[15:0];
          b_d     = B[15:0];
          r_d     = {3'b001, A[6:0]};
          q_d     = 10'd0;
          cnt_d   = 4'd0;
          ph_d    = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        r_d = ge ? (rsh - dvx) : rsh;
        q_d = {q_q[8:0], ge};
        if (cnt_q == 4'd9) begin
          cnt_d   = 4'd0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      NORM: begin
        if (!ph_q) begin
          ph_d = 1'b1;
          if (q_q[9]) begin
            m_d  = q_q[8:2];
            g_d  = q_q[1];
            st_d = q_q[0] | (r_q != 10'd0);
            e_d  = $signed({2'b00, a_q[14:7]}) - $signed({2'b00, b_q[14:7]}) + 10'sd127;
          end else begin
            m_d  = q_q[7:1];
            g_d  = q_q[0];
            st_d = (r_q != 10'd0);
            e_d  = $signed({2'b00, a_q[14:7]}) - $signed({2'b00, b_q[14:7]}) + 10'sd126;
          end
        end else begin
          ph_d    = 1'b0;
          o_d     = pk;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      r_q     <= 10'd0;
      q_q     <= 10'd0;
      ph_q    <= 1'b0;
      m_q     <= 7'd0;
      g_q     <= 1'b0;
      st_q    <= 1'b0;
      e_q     <= 10'sd0;
      o_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      ph_q    <= ph_d;
      m_q     <= m_d;
      g_q     <= g_d;
      st_q    <= st_d;
      e_q     <= e_d;
      o_q     <= o_d;
    end
  end

endmodule
